user_data_mem_ctrl: RTL and testbench
=====================================

Name: user_data_mem_ctrl

Overview:
Controller for the i281 user data memory (16 x 8-bit). After reset it sequences a byte-serial load of the constant initial data image into a writable register file. It then serves the CPU data port with zero-latency reads and single-cycle writes. A debug/loader port shares the memory through a req/ack handshake with an anti-starvation rule.

Parameters:
DEPTH, 16, number of data bytes; the address width is 4 bits at the default.
WIDTH, 8, bits per data word.
STARVE_LIMIT, 4, number of consecutive blocked cycles of a pending debug write before the CPU is stalled for one cycle.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
init_image  in  DEPTH*WIDTH  constant initial image; byte i is at [8i+7:8i]
reinit  in  1  single-cycle pulse that restarts the init sequence
busy  out  1  high while in INIT
cpu_addr  in  4  CPU data address
cpu_we  in  1  CPU write enable
cpu_wdata  in  WIDTH  CPU write data
cpu_rdata  out  WIDTH  combinational read of mem[cpu_addr]
cpu_stall  out  1  CPU must hold its state this cycle
dbg_req  in  1  debug request; held high until dbg_ack
dbg_we  in  1  debug write (1) or read (0); stable while dbg_req is high
dbg_addr  in  4  debug address
dbg_wdata  in  WIDTH  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  WIDTH  registered read data; valid while dbg_ack is high, then held

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values:
  - mem all 0.
  - state=INIT, ptr=0, starve_cnt=0.
  - busy=1, cpu_stall=1, dbg_ack=0, dbg_rdata=0.
- INIT state:
  - Each cycle: mem[ptr] <= init_image byte ptr, then ptr++.
  - When ptr==DEPTH-1 the write still occurs, then the next state is RUN.
  - The load takes exactly DEPTH cycles after reset release.
  - busy=1 and cpu_stall=1 throughout.
  - dbg_req is ignored (no ack). A pending request is served after entry to RUN.
- RUN state: busy=0.
  - cpu_rdata = mem[cpu_addr] in all states (combinational).
  - CPU write: mem[cpu_addr] <= cpu_wdata when cpu_we=1 and cpu_stall=0.
  - Debug read: granted on any RUN cycle with dbg_req=1 and no ack this cycle. dbg_rdata <= mem[dbg_addr] (pre-write value if the CPU writes the same address that cycle). dbg_ack=1 on the next cycle.
  - Debug write: granted when dbg_req=1, dbg_we=1 and (cpu_we=0 or cpu_stall=1).
    - mem[dbg_addr] <= dbg_wdata.
    - dbg_ack=1 on the next cycle.
    - dbg_rdata <= dbg_wdata.
  - Back-to-back: a request still high during its ack cycle is treated as a new request only from the cycle after the ack. At most one ack per 2 cycles.
  - Anti-starvation:
    - starve_cnt increments each RUN cycle a debug write is pending but blocked by cpu_we.
    - When starve_cnt==STARVE_LIMIT: cpu_stall=1 for exactly that one cycle, the debug write is granted, and starve_cnt is cleared.
    - starve_cnt is also cleared on any grant and whenever dbg_req=0.
    - Otherwise cpu_stall=0 in RUN.
- Write collision: CPU and debug never write in the same cycle by construction.
- reinit:
  - In RUN: next state INIT, ptr=0. Memory contents are overwritten progressively.
  - An in-flight dbg_ack still pulses on the following cycle.
  - Later requests wait for RUN.
  - In INIT: ptr restarts at 0.
- Reset asserted mid-INIT or mid-RUN: immediate return to all reset values.
- Address range: addresses are 4-bit, so every value is in range and no wrap-around logic is needed. ptr never exceeds DEPTH-1.

Test Plan:
- Init load: image bytes 0..4 = FE,03,04,01,03, rest 00; release rst_n. Required: busy=1 for 16 cycles then 0; cpu_rdata at addr 0/1/4 = FE/03/03; addr 15 = 00.
- CPU access: in RUN write 0x5A to addr 7. Required: cpu_rdata at addr 7 = 5A on the following cycle; a read with the same address in the write cycle shows the old value 00.
- Debug read: dbg_req, dbg_we=0, addr 2 while the CPU writes 0x77 to addr 2. Required: dbg_ack next cycle, dbg_rdata=04; the CPU later reads 77.
- Starvation: hold cpu_we=1 continuously; issue a debug write of 0xAA to addr 9. Required: cpu_stall=1 for exactly one cycle after 4 blocked cycles, dbg_ack the next cycle, mem[9]=AA, and the CPU write in the stalled cycle is not performed.
- reinit mid-run: modify addr 0 to 0x11, pulse reinit. Required: busy=1 for 16 cycles, then mem[0]=FE.
- Async reset mid-INIT: assert rst_n=0 at cycle 5 of the load. Required: outputs return to reset values immediately, without waiting for a clock edge; the full 16-cycle load reruns after release.

Source files
------------

// File: rtl/user_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// user_data_mem_ctrl
//
// Controller for the i281 user data memory (DEPTH x WIDTH register file).
// After reset, or on a reinit pulse, the constant initial image is copied into
// the register file one byte per cycle (INIT). After that (RUN), the CPU data
// port gets zero-latency reads and single-cycle writes. A debug/loader port
// shares the memory through a req/ack handshake. A debug write that the CPU
// keeps blocking is forced through after STARVE_LIMIT blocked cycles by
// stalling the CPU for one cycle.
//
// Ports:
//   clk, rst_n   system clock (rising edge), asynchronous active-low reset
//   init_image   constant initial image, byte i at [WIDTH*i +: WIDTH]
//   reinit       single-cycle pulse that restarts the init sequence
//   busy         high while the initial image is being loaded
//   cpu_addr     CPU data address
//   cpu_we       CPU write enable (ignored while cpu_stall is high)
//   cpu_wdata    CPU write data
//   cpu_rdata    combinational read of mem[cpu_addr]
//   cpu_stall    CPU must hold its state this cycle
//   dbg_req      debug request, held high until dbg_ack
//   dbg_we       debug write (1) / read (0), stable while dbg_req is high
//   dbg_addr     debug address
//   dbg_wdata    debug write data
//   dbg_ack      one-cycle completion pulse
//   dbg_rdata    registered debug read data, held after the ack
// -----------------------------------------------------------------------------
module user_data_mem_ctrl #(
    parameter int DEPTH        = 16,
    parameter int WIDTH        = 8,
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DEPTH*WIDTH-1:0]   init_image,
    input  logic                     reinit,
    output logic                     busy,
    input  logic [AW-1:0]            cpu_addr,
    input  logic                     cpu_we,
    input  logic [WIDTH-1:0]         cpu_wdata,
    output logic [WIDTH-1:0]         cpu_rdata,
    output logic                     cpu_stall,
    input  logic                     dbg_req,
    input  logic                     dbg_we,
    input  logic [AW-1:0]            dbg_addr,
    input  logic [WIDTH-1:0]         dbg_wdata,
    output logic                     dbg_ack,
    output logic [WIDTH-1:0]         dbg_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic [SW-1:0]       starve_cnt_q, starve_cnt_d;
    logic                ack_q;
    logic [WIDTH-1:0]    rdata_q, rdata_d;
    logic [WIDTH-1:0]    mem [DEPTH];

    logic                run;
    logic                dbg_ready;
    logic                starve_hit;
    logic                dbg_rd_grant;
    logic                dbg_wr_grant;
    logic                cpu_wr_en;
    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic [WIDTH-1:0]    mem_wdata;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign run        = (state_q == ST_RUN);
    // A request still high during its own ack cycle is not a new request.
    assign dbg_ready  = run && dbg_req && !ack_q;
    assign starve_hit = run && (starve_cnt_q == SW'(STARVE_LIMIT));

    assign cpu_stall    = !run || starve_hit;
    assign dbg_rd_grant = dbg_ready && !dbg_we;
    // The stall cycle frees the write port, so the starved write goes through.
    assign dbg_wr_grant = dbg_ready && dbg_we && (!cpu_we || cpu_stall);
    assign cpu_wr_en    = run && cpu_we && !cpu_stall;

    assign busy      = !run;
    assign cpu_rdata = mem[cpu_addr];
    assign dbg_ack   = ack_q;
    assign dbg_rdata = rdata_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d      = state_q;
        ptr_d        = ptr_q;
        starve_cnt_d = starve_cnt_q;
        rdata_d      = rdata_q;
        mem_we       = 1'b0;
        mem_waddr    = cpu_addr;
        mem_wdata    = cpu_wdata;

        unique case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = init_image[ptr_q*WIDTH +: WIDTH];
                if (reinit) begin
                    ptr_d = '0;
                end else if (ptr_q == AW'(DEPTH - 1)) begin
                    ptr_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end

            ST_RUN: begin
                if (dbg_wr_grant) begin
                    mem_we    = 1'b1;
                    mem_waddr = dbg_addr;
                    mem_wdata = dbg_wdata;
                end else if (cpu_wr_en) begin
                    mem_we    = 1'b1;
                    mem_waddr = cpu_addr;
                    mem_wdata = cpu_wdata;
                end
                if (reinit) begin
                    state_d = ST_INIT;
                    ptr_d   = '0;
                end
            end

            default: state_d = ST_INIT;
        endcase

        // Debug read samples the memory before this cycle's write lands.
        if (dbg_rd_grant) rdata_d = mem[dbg_addr];
        if (dbg_wr_grant) rdata_d = dbg_wdata;

        if (!run || !dbg_req || dbg_rd_grant || dbg_wr_grant || starve_hit)
            starve_cnt_d = '0;
        else if (dbg_ready && dbg_we && cpu_we)
            starve_cnt_d = starve_cnt_q + 1'b1;
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state_q      <= ST_INIT;
            ptr_q        <= '0;
            starve_cnt_q <= '0;
            ack_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            starve_cnt_q <= starve_cnt_d;
            ack_q        <= dbg_rd_grant || dbg_wr_grant;
            rdata_q      <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the memory is reset here because the contents must read as
        // zero immediately on reset; this keeps it a flop array rather than
        // an inferred RAM macro.
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_user_data_mem_ctrl.sv
module tb_user_data_mem_ctrl;

    logic         clk;
    logic         rst_n;
    logic [127:0] init_image;
    logic         reinit;
    logic         busy;
    logic [3:0]   cpu_addr;
    logic         cpu_we;
    logic [7:0]   cpu_wdata;
    logic [7:0]   cpu_rdata;
    logic         cpu_stall;
    logic         dbg_req;
    logic         dbg_we;
    logic [3:0]   dbg_addr;
    logic [7:0]   dbg_wdata;
    logic         dbg_ack;
    logic [7:0]   dbg_rdata;

    int n_vec  = 0;
    int n_fail = 0;

    user_data_mem_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_image (init_image),
        .reinit     (reinit),
        .busy       (busy),
        .cpu_addr   (cpu_addr),
        .cpu_we     (cpu_we),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_ack    (dbg_ack),
        .dbg_rdata  (dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cpu_addr;
        logic       cpu_we;
        logic [7:0] cpu_wdata;
        logic       dbg_req;
        logic       dbg_we;
        logic [3:0] dbg_addr;
        logic [7:0] dbg_wdata;
        logic [7:0] exp_rdata;
        logic       exp_stall;
        logic       exp_ack;
        logic [7:0] exp_drd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] ca, logic cw, logic [7:0] cd,
                                logic dr, logic dw, logic [3:0] da, logic [7:0] dd,
                                logic [7:0] er, logic es, logic ea, logic [7:0] ed);
        vec_t v;
        v.cpu_addr = ca; v.cpu_we = cw; v.cpu_wdata = cd;
        v.dbg_req = dr; v.dbg_we = dw; v.dbg_addr = da; v.dbg_wdata = dd;
        v.exp_rdata = er; v.exp_stall = es; v.exp_ack = ea; v.exp_drd = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_cpu(input logic [3:0] a, input logic [7:0] exp, input string name);
        cpu_addr = a;
        #1;
        check(name, cpu_rdata, exp);
    endtask

    // Counts clock edges until busy falls; also flags any ack while loading.
    task automatic count_init(input string name);
        int n;
        bit saw_ack;
        n = 0;
        saw_ack = 0;
        while (busy && n < 40) begin
            if (dbg_ack) saw_ack = 1;
            if (!cpu_stall) saw_ack = 1;
            step();
            n++;
        end
        check({name, "_cycles"}, n, 16);
        check({name, "_no_ack_stall_hi"}, saw_ack, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        init_image = {88'h0, 8'h03, 8'h01, 8'h04, 8'h03, 8'hFE};
        rst_n = 1'b0; reinit = 1'b0;
        cpu_addr = 4'd0; cpu_we = 1'b0; cpu_wdata = 8'h00;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 4'd0; dbg_wdata = 8'h00;

        // Reset values
        #1;
        check("rst_busy", busy, 1);
        check("rst_stall", cpu_stall, 1);
        check("rst_ack", dbg_ack, 0);
        check("rst_dbg_rdata", dbg_rdata, 8'h00);
        check("rst_mem0", cpu_rdata, 8'h00);

        // Initial load, with a debug read already pending during INIT
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 4'd4;
        @(negedge clk);
        rst_n = 1'b1;
        count_init("init");
        read_cpu(4'd0, 8'hFE, "init_mem0");
        read_cpu(4'd1, 8'h03, "init_mem1");
        read_cpu(4'd4, 8'h03, "init_mem4");
        read_cpu(4'd15, 8'h00, "init_mem15");
        check("run_stall", cpu_stall, 0);
        check("run_ack_not_yet", dbg_ack, 0);
        step();
        check("pend_ack", dbg_ack, 1);
        check("pend_rdata", dbg_rdata, 8'h03);
        dbg_req = 1'b0;
        step();

        // Table: one cycle per record, outputs checked before the edge.
        //           ca  cw cd     dr dw da  dd     er     es ea ed
        // CPU write / readback
        vecs.push_back(mk(4'd7, 1, 8'h5A, 0, 0, 4'd0, 8'h00, 8'h00, 0, 0, 8'h03));
        vecs.push_back(mk(4'd7, 0, 8'h00, 0, 0, 4'd0, 8'h00, 8'h5A, 0, 0, 8'h03));
        // Debug read racing a CPU write to the same address
        vecs.push_back(mk(4'd2, 1, 8'h77, 1, 0, 4'd2, 8'h00, 8'h04, 0, 0, 8'h03));
        // Request still high in ack cycle: no new grant until next cycle
        vecs.push_back(mk(4'd2, 0, 8'h00, 1, 0, 4'd2, 8'h00, 8'h77, 0, 1, 8'h04));
        vecs.push_back(mk(4'd2, 0, 8'h00, 1, 0, 4'd2, 8'h00, 8'h77, 0, 0, 8'h04));
        vecs.push_back(mk(4'd2, 0, 8'h00, 0, 0, 4'd2, 8'h00, 8'h77, 0, 1, 8'h77));
        // Uncontended debug write
        vecs.push_back(mk(4'd3, 0, 8'h00, 1, 1, 4'd3, 8'hC3, 8'h01, 0, 0, 8'h77));
        vecs.push_back(mk(4'd3, 0, 8'h00, 0, 0, 4'd3, 8'h00, 8'hC3, 0, 1, 8'hC3));
        // Starvation: CPU writes addr 10 every cycle, debug write AA -> addr 9
        vecs.push_back(mk(4'd10, 1, 8'h01, 1, 1, 4'd9, 8'hAA, 8'h00, 0, 0, 8'hC3));
        vecs.push_back(mk(4'd10, 1, 8'h02, 1, 1, 4'd9, 8'hAA, 8'h01, 0, 0, 8'hC3));
        vecs.push_back(mk(4'd10, 1, 8'h03, 1, 1, 4'd9, 8'hAA, 8'h02, 0, 0, 8'hC3));
        vecs.push_back(mk(4'd10, 1, 8'h04, 1, 1, 4'd9, 8'hAA, 8'h03, 0, 0, 8'hC3));
        vecs.push_back(mk(4'd10, 1, 8'h05, 1, 1, 4'd9, 8'hAA, 8'h04, 1, 0, 8'hC3));
        vecs.push_back(mk(4'd10, 1, 8'h06, 0, 1, 4'd9, 8'hAA, 8'h04, 0, 1, 8'hAA));
        vecs.push_back(mk(4'd9,  0, 8'h00, 0, 0, 4'd0, 8'h00, 8'hAA, 0, 0, 8'hAA));
        vecs.push_back(mk(4'd10, 0, 8'h00, 0, 0, 4'd0, 8'h00, 8'h06, 0, 0, 8'hAA));

        for (int i = 0; i < vecs.size(); i++) begin
            cpu_addr = vecs[i].cpu_addr; cpu_we = vecs[i].cpu_we; cpu_wdata = vecs[i].cpu_wdata;
            dbg_req = vecs[i].dbg_req; dbg_we = vecs[i].dbg_we;
            dbg_addr = vecs[i].dbg_addr; dbg_wdata = vecs[i].dbg_wdata;
            #1;
            check($sformatf("v%0d_rdata", i), cpu_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_stall", i), cpu_stall, vecs[i].exp_stall);
            check($sformatf("v%0d_ack", i), dbg_ack, vecs[i].exp_ack);
            check($sformatf("v%0d_dbg_rdata", i), dbg_rdata, vecs[i].exp_drd);
            step();
        end
        cpu_we = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;

        // reinit mid-run after modifying addr 0
        cpu_addr = 4'd0; cpu_we = 1'b1; cpu_wdata = 8'h11;
        step();
        cpu_we = 1'b0;
        #1;
        check("mod_mem0", cpu_rdata, 8'h11);
        reinit = 1'b1;
        step();
        reinit = 1'b0;
        check("reinit_busy", busy, 1);
        count_init("reinit");
        read_cpu(4'd0, 8'hFE, "reinit_mem0");
        read_cpu(4'd3, 8'h01, "reinit_mem3");
        read_cpu(4'd9, 8'h00, "reinit_mem9");
        read_cpu(4'd7, 8'h00, "reinit_mem7");
        check("reinit_dbg_rdata_held", dbg_rdata, 8'hAA);

        // Async reset in the middle of a load
        reinit = 1'b1;
        step();
        reinit = 1'b0;
        repeat (5) step();
        cpu_addr = 4'd0;
        #1;
        check("midinit_mem0_loaded", cpu_rdata, 8'hFE);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1);
        check("arst_stall", cpu_stall, 1);
        check("arst_ack", dbg_ack, 0);
        check("arst_dbg_rdata", dbg_rdata, 8'h00);
        check("arst_mem0", cpu_rdata, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        count_init("rerun");
        read_cpu(4'd0, 8'hFE, "rerun_mem0");
        read_cpu(4'd2, 8'h04, "rerun_mem2");
        read_cpu(4'd10, 8'h00, "rerun_mem10");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
